// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two byte requesters with per-byte round-robin.
// Latency: valid sampled in IDLE at edge k -> o_tx_start/ack in cycle k+1; >= 4 cycles + frame per byte.
// Backpressure: requesters hold valid until their ack pulse; the uart gates progress via i_tx_done or watchdog.
module uart_tx_arbiter #(
   parameter int NB_DATA  = 8,
   parameter int NB_TIMER = 20
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_req0_valid,
   input  logic [NB_DATA-1:0] i_req0_data,
   output logic               o_req0_ack,
   input  logic               i_req1_valid,
   input  logic [NB_DATA-1:0] i_req1_data,
   output logic               o_req1_ack,
   input  logic               i_tx_done,
   output logic               o_tx_start,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_grant,
   output logic               o_busy,
   output logic               o_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_GAP       = 2'd3
   } state_t;

   localparam logic [NB_TIMER-1:0] TIMER_MAX = '1;
   localparam logic [NB_TIMER-1:0] TIMER_ONE = {{(NB_TIMER-1){1'b0}}, 1'b1};

   state_t               state_q,    state_d;
   logic [NB_TIMER-1:0]  timer_q,    timer_d;
   logic [NB_DATA-1:0]   tx_data_q,  tx_data_d;
   logic                 grant_q,    grant_d;
   logic                 tx_start_q, tx_start_d;
   logic                 ack0_q,     ack0_d;
   logic                 ack1_q,     ack1_d;
   logic                 timeout_q,  timeout_d;

   logic                 pick_vld;
   logic                 pick_idx;

   // Arbitration: a lone requester wins outright; on a tie the one not granted last time wins.
   always_comb begin
      pick_vld = i_req0_valid | i_req1_valid;
      pick_idx = 1'b0;
      if (i_req0_valid && i_req1_valid) begin
         pick_idx = ~grant_q;
      end else if (i_req1_valid) begin
         pick_idx = 1'b1;
      end
   end

   // Next-state and next-output logic; pulse outputs default low so they last exactly one cycle.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      tx_data_d  = tx_data_q;
      grant_d    = grant_q;
      tx_start_d = 1'b0;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      timeout_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               // Latch the byte on the grant edge so a requester dropping valid early cannot corrupt it.
               state_d    = ST_START;
               grant_d    = pick_idx;
               tx_data_d  = pick_idx ? i_req1_data : i_req0_data;
               tx_start_d = 1'b1;
               ack0_d     = ~pick_idx;
               ack1_d     = pick_idx;
            end
         end

         ST_START: begin
            timer_d = '0;
            state_d = ST_WAIT_DONE;
         end

         ST_WAIT_DONE: begin
            // A completion in the same cycle the watchdog expires still counts as a clean finish.
            if (i_tx_done) begin
               state_d = ST_GAP;
            end else if (timer_q == TIMER_MAX) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end

         ST_GAP: begin
            // One idle guard cycle lets the uart settle before the next start pulse.
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any in-flight byte without pulsing start or ack.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         tx_data_q  <= '0;
         grant_q    <= 1'b1;
         tx_start_q <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         tx_data_q  <= tx_data_d;
         grant_q    <= grant_d;
         tx_start_q <= tx_start_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         timeout_q  <= timeout_d;
      end
   end

   assign o_tx_start = tx_start_q;
   assign o_req0_ack = ack0_q;
   assign o_req1_ack = ack1_q;
   assign o_tx_data  = tx_data_q;
   assign o_grant    = grant_q;
   assign o_timeout  = timeout_q;
   assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed requests, scoreboard of expected grants checked by a monitor.
// Latency: n/a.
// Backpressure: requester model holds each byte until its ack.
module tb_uart_tx_arbiter;

   localparam int NB_DATA  = 8;
   localparam int NB_TIMER = 4;

   logic               clk = 1'b0;
   logic               i_reset = 1'b1;
   logic               i_req0_valid = 1'b0;
   logic [NB_DATA-1:0] i_req0_data = '0;
   logic               i_req1_valid = 1'b0;
   logic [NB_DATA-1:0] i_req1_data = '0;
   logic               i_tx_done = 1'b0;
   logic               o_req0_ack, o_req1_ack, o_tx_start, o_grant, o_busy, o_timeout;
   logic [NB_DATA-1:0] o_tx_data;

   uart_tx_arbiter #(.NB_DATA(NB_DATA), .NB_TIMER(NB_TIMER)) dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_req0_valid (i_req0_valid),
      .i_req0_data  (i_req0_data),
      .o_req0_ack   (o_req0_ack),
      .i_req1_valid (i_req1_valid),
      .i_req1_data  (i_req1_data),
      .o_req1_ack   (o_req1_ack),
      .i_tx_done    (i_tx_done),
      .o_tx_start   (o_tx_start),
      .o_tx_data    (o_tx_data),
      .o_grant      (o_grant),
      .o_busy       (o_busy),
      .o_timeout    (o_timeout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic               idx;
      logic [NB_DATA-1:0] dat;
   } exp_t;

   exp_t               exp_q[$];
   logic [NB_DATA-1:0] q0[$];
   logic [NB_DATA-1:0] q1[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_delay = 1;
   bit done_en = 1'b1;
   bit done_kick = 1'b0;
   int timeout_cnt = 0;
   int timeout_cyc = 0;
   int last_start = -100;
   int req0_rise = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input string name, output int sc);
      int n;
      n = 0;
      while (!o_tx_start && n < 60) begin
         tick();
         n++;
      end
      chk(name, o_tx_start, 1);
      sc = cyc;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || o_busy) && n < 200) begin
         tick();
         n++;
      end
      chk({name, "_left"}, exp_q.size(), 0);
      chk({name, "_busy"}, o_busy, 0);
   endtask

   task automatic push0(input logic [NB_DATA-1:0] d);
      q0.push_back(d);
      exp_q.push_back('{idx: 1'b0, dat: d});
   endtask

   task automatic push1(input logic [NB_DATA-1:0] d);
      q1.push_back(d);
      exp_q.push_back('{idx: 1'b1, dat: d});
   endtask

   initial begin
      fork
         // cycle counter
         forever begin
            @(posedge clk);
            cyc++;
         end

         // requester model: pop a byte on its ack, otherwise keep presenting the queue head
         forever begin
            @(posedge clk);
            #1;
            if (o_req0_ack && q0.size() > 0) void'(q0.pop_front());
            if (o_req1_ack && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) begin
               if (!i_req0_valid) req0_rise = cyc;
               i_req0_valid = 1'b1;
               i_req0_data  = q0[0];
            end else begin
               i_req0_valid = 1'b0;
               i_req0_data  = '0;
            end
            if (q1.size() > 0) begin
               i_req1_valid = 1'b1;
               i_req1_data  = q1[0];
            end else begin
               i_req1_valid = 1'b0;
               i_req1_data  = '0;
            end
         end

         // uart model: tx_done arrives done_delay cycles after the start cycle
         begin
            int cnt;
            cnt = 0;
            forever begin
               @(posedge clk);
               #2;
               if (i_reset) begin
                  cnt       = 0;
                  i_tx_done = 1'b0;
               end else begin
                  i_tx_done = done_kick;
                  done_kick = 1'b0;
                  if (cnt > 0) begin
                     cnt--;
                     if (cnt == 0) i_tx_done = 1'b1;
                  end
                  if (o_tx_start && done_en) cnt = done_delay;
               end
            end
         end

         // monitor: every start pulse is checked against the scoreboard head
         forever begin
            @(negedge clk);
            if (o_tx_start) begin
               chk("start_gap_ge4", (cyc - last_start) >= 4, 1);
               last_start = cyc;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_start actual=data_%0h required=no_start", o_tx_data);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("tx_data", o_tx_data, e.dat);
                  chk("grant", o_grant, e.idx);
                  chk("ack0", o_req0_ack, !e.idx);
                  chk("ack1", o_req1_ack, e.idx);
               end
            end else if (o_req0_ack || o_req1_ack) begin
               chk("stray_ack", {o_req0_ack, o_req1_ack}, 0);
            end
            if (o_timeout) begin
               timeout_cnt++;
               timeout_cyc = cyc;
            end
         end

         // directed stimulus
         begin
            int s;
            int n;
            int t0;
            repeat (3) tick();
            i_reset = 1'b0;
            tick();
            chk("rst_busy", o_busy, 0);
            chk("rst_start", o_tx_start, 0);
            chk("rst_ack0", o_req0_ack, 0);
            chk("rst_ack1", o_req1_ack, 0);
            chk("rst_timeout", o_timeout, 0);
            chk("rst_data", o_tx_data, 0);
            chk("rst_grant", o_grant, 1);

            // 1: single request, done 3 cycles after start -> GAP at s+4, IDLE at s+5
            done_en = 1'b1;
            done_delay = 3;
            push0(8'h2A);
            wait_start("t1_start", s);
            chk("t1_latency", s - req0_rise, 1);
            chk("t1_data", o_tx_data, 8'h2A);
            chk("t1_grant", o_grant, 0);
            repeat (4) tick();
            chk("t1_busy_gap", o_busy, 1);
            tick();
            chk("t1_busy_idle", o_busy, 0);

            // 2: both valid straight out of reset -> req0 first since o_grant resets to 1
            done_delay = 1;
            i_reset = 1'b1;
            push0(8'h11);
            push1(8'h22);
            repeat (2) tick();
            i_reset = 1'b0;
            wait_drain("t2");

            // 3: both held for four bytes -> grants 0,1,0,1 with starts 4 cycles apart
            push0(8'hA0);
            push1(8'hB1);
            push0(8'hA2);
            push1(8'hB3);
            wait_drain("t3");

            // 4: no tx_done -> WAIT_DONE with timer 0..15, pulse registered at s+17
            done_en = 1'b0;
            push0(8'h5A);
            wait_start("t4_start", s);
            n = 0;
            while (!o_timeout && n < 40) begin
               tick();
               n++;
            end
            chk("t4_timeout_seen", o_timeout, 1);
            chk("t4_timeout_delay", cyc - s, 17);
            chk("t4_busy_at_timeout", o_busy, 0);
            tick();
            chk("t4_timeout_width", o_timeout, 0);
            done_en = 1'b1;
            done_delay = 2;
            push1(8'h77);
            wait_drain("t4_next");

            // 5: tx_done lands in the cycle timer is all-ones -> GAP at s+17, IDLE at s+18, no timeout
            done_delay = 16;
            t0 = timeout_cnt;
            push0(8'h99);
            wait_start("t5_start", s);
            n = 0;
            while (o_busy && n < 40) begin
               tick();
               n++;
            end
            chk("t5_idle_cycle", cyc - s, 18);
            chk("t5_no_timeout", timeout_cnt, t0);

            // 6: reset while waiting for tx_done, then a late tx_done must be ignored
            done_en = 1'b0;
            push1(8'h3C);
            wait_start("t6_start", s);
            repeat (2) tick();
            chk("t6_busy_before", o_busy, 1);
            i_reset = 1'b1;
            tick();
            chk("t6_busy", o_busy, 0);
            chk("t6_start", o_tx_start, 0);
            chk("t6_grant", o_grant, 1);
            chk("t6_data", o_tx_data, 0);
            i_reset = 1'b0;
            done_kick = 1'b1;
            repeat (4) tick();
            chk("t6_busy_after_done", o_busy, 0);
            chk("t6_no_start", o_tx_start, 0);

            chk("total_timeouts", timeout_cnt, 1);
            chk("scoreboard_empty", exp_q.size(), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      join_none
   end

endmodule
